// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: collects WIDTH serial bits (MSB first) into a
// frame, publishes it on P and strobes V for one clock when the frame completes.
module sipo_deser #(
    parameter int WIDTH = 4,
    parameter int CW    = 2
) (
    input  logic             C,
    input  logic             nR,
    input  logic             D,
    input  logic             EN,
    output logic [WIDTH-1:0] P,
    output logic             V,
    output logic [CW-1:0]    CNT
);

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_LAST = 1'b1
    } phase_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_next_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] p_next_s;
    logic             v_r;
    logic             v_next_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next_s;
    phase_t           phase_s;

    // Phase is implied by the bit counter: the last bit of a frame completes it.
    always_comb begin
        shifted_s = {shift_r[WIDTH-2:0], D};
        if (cnt_r == LAST_CNT) begin
            phase_s = PH_LAST;
        end else begin
            phase_s = PH_FILL;
        end
    end

    // Next-state logic; EN=0 freezes the frame and terminates any strobe.
    always_comb begin
        shift_next_s = shift_r;
        p_next_s     = p_r;
        cnt_next_s   = cnt_r;
        v_next_s     = 1'b0;
        if (EN) begin
            case (phase_s)
                PH_FILL: begin
                    shift_next_s = shifted_s;
                    cnt_next_s   = cnt_r + CW'(1);
                end
                PH_LAST: begin
                    shift_next_s = shifted_s;
                    p_next_s     = shifted_s;
                    cnt_next_s   = {CW{1'b0}};
                    v_next_s     = 1'b1;
                end
                default: begin
                    shift_next_s = {WIDTH{1'b0}};
                    cnt_next_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            v_next_s = 1'b0;
        end
    end

    // State and output registers; reset discards any partial frame and the last P.
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            shift_r <= {WIDTH{1'b0}};
            p_r     <= {WIDTH{1'b0}};
            v_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            shift_r <= shift_next_s;
            p_r     <= p_next_s;
            v_r     <= v_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign P   = p_r;
    assign V   = v_r;
    assign CNT = cnt_r;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: queue-based frame model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_sipo_deser;

    localparam int WIDTH = 4;
    localparam int CW    = 2;

    logic             C = 1'b0;
    logic             nR = 1'b0;
    logic             en_drv = 1'b0;
    logic             d_drv = 1'b0;
    logic             dff_mode = 1'b0;
    logic             src = 1'b0;
    logic             dff_q = 1'b0;
    logic             d_in;
    logic [WIDTH-1:0] P;
    logic             V;
    logic [CW-1:0]    CNT;

    int errors = 0;
    int checks = 0;

    int         model_bits[$];
    logic [3:0] exp_p = 4'b0000;
    logic       exp_v = 1'b0;
    int         exp_cnt = 0;

    assign d_in = dff_mode ? dff_q : d_drv;

    sipo_deser #(.WIDTH(WIDTH), .CW(CW)) dut (
        .C   (C),
        .nR  (nR),
        .D   (d_in),
        .EN  (en_drv),
        .P   (P),
        .V   (V),
        .CNT (CNT)
    );

    always #5 C = ~C;

    // Upstream stimulus source and a dff with a 1-unit clock-to-Q delay.
    always #13 src = ~src;
    always @(posedge C) begin
        logic tmp;
        tmp = src;
        #1 dff_q = tmp;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: captured bits live in a queue; a full queue becomes the published frame.
    always @(posedge C) begin
        if (nR) begin
            exp_v = 1'b0;
            if (en_drv) begin
                model_bits.push_back(int'(d_in));
                if (model_bits.size() == WIDTH) begin
                    int val;
                    val = 0;
                    foreach (model_bits[i]) val = val * 2 + model_bits[i];
                    exp_p = val[3:0];
                    exp_v = 1'b1;
                    model_bits.delete();
                end
            end
            exp_cnt = model_bits.size();
        end
    end

    always @(negedge nR) begin
        model_bits.delete();
        exp_p   = 4'b0000;
        exp_v   = 1'b0;
        exp_cnt = 0;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge C) begin
        check("cyc_p", int'(P), int'(exp_p));
        check("cyc_v", int'(V), int'(exp_v));
        check("cyc_cnt", int'(CNT), exp_cnt);
        check("cyc_noX", int'($isunknown({P, V, CNT})), 0);
    end

    task automatic step(input logic d, input logic en);
        d_drv  = d;
        en_drv = en;
        @(posedge C);
        #1;
    endtask

    initial begin
        logic [3:0] f1011;
        f1011 = 4'b1011;
        nR = 1'b0;
        #2;
        check("rst_p", int'(P), 0);
        check("rst_v", int'(V), 0);
        check("rst_cnt", int'(CNT), 0);
        #10 nR = 1'b1;

        // 1: first frame 1011
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("t1_cnt3", int'(CNT), 3);
        check("t1_v_pre", int'(V), 0);
        step(1'b1, 1'b1);
        check("t1_p", int'(P), int'(f1011));
        check("t1_v", int'(V), 1);
        check("t1_cnt", int'(CNT), 0);
        check("t1_model_p", int'(exp_p), int'(f1011));

        // 2: back-to-back frame 0110
        step(1'b0, 1'b1);
        check("t2_v_end", int'(V), 0);
        check("t2_p_hold", int'(P), int'(f1011));
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("t2_p_hold3", int'(P), int'(f1011));
        check("t2_v3", int'(V), 0);
        step(1'b0, 1'b1);
        check("t2_p", int'(P), 6);
        check("t2_v", int'(V), 1);

        // 3: pause mid-frame
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("t3_pause_cnt", int'(CNT), 2);
            check("t3_pause_v", int'(V), 0);
        end
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("t3_p", int'(P), 13);
        check("t3_v", int'(V), 1);
        check("t3_model_p", int'(exp_p), 13);

        // 4: reset with three bits captured
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("t4_cnt_pre", int'(CNT), 3);
        #1 nR = 1'b0;
        #1;
        check("t4_rst_p", int'(P), 0);
        check("t4_rst_v", int'(V), 0);
        check("t4_rst_cnt", int'(CNT), 0);
        #1 nR = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("t4_p_zero", int'(P), 0);
        step(1'b1, 1'b1);
        check("t4_p", int'(P), 15);
        check("t4_v", int'(V), 1);

        // 5: continuous toggling, strobe every fourth edge
        for (int k = 0; k < 16; k++) begin
            step(((k % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
            if ((k % 4) == 3) begin
                check("t5_v", int'(V), 1);
                check("t5_p", int'(P), 10);
            end else begin
                check("t5_v_low", int'(V), 0);
            end
        end

        // 6: data from the upstream dff; per-cycle model checking covers it
        dff_mode = 1'b1;
        for (int k = 0; k < 64; k++) step(1'b0, 1'b1);
        dff_mode = 1'b0;
        step(1'b0, 1'b0);
        check("t6_v_off", int'(V), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
